// File: rtl/cen_timer_if.sv
// Bus-side write port of cen_timer: reload value and counting mode.
// No ready: wr_en is a fire-and-forget strobe. Every cycle with wr_en=1 is a write, and the last write wins.
interface cen_timer_if #(
    parameter int WIDTH = 16
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_mode;

    modport master (
        output wr_en,
        output wr_data,
        output wr_mode
    );

    modport slave (
        input wr_en,
        input wr_data,
        input wr_mode
    );
endinterface

// File: rtl/cen_timer.sv
// 8253-style timer channel: rate generator (mode 0) or square wave (mode 1),
// advanced by a one-cycle clock-enable strobe and gated/retriggered by gate.
module cen_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cen,
    input  logic             gate,
    cen_timer_if.slave       bus,
    output logic             out,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             out_nxt;
    logic [WIDTH-1:0] reload;
    logic             mode_r;
    logic             gate_d;
    logic             gate_rise;

    // Effective period: 0 means 2^WIDTH, 1 is promoted to 2.
    logic [WIDTH:0]   n_eff;
    logic [WIDTH-1:0] n_low;
    logic [WIDTH-1:0] half_hi;
    logic [WIDTH-1:0] half_lo;

    assign gate_rise = gate & ~gate_d;
    assign fsm_state = state;

    always_comb begin
        n_eff = {1'b0, reload};
        if (reload == '0) begin
            n_eff = {1'b1, {WIDTH{1'b0}}};
        end else if (reload == ONE) begin
            n_eff = {1'b0, TWO};
        end
        // For 2^WIDTH in mode 0 the low bits are 0, which counts 0 -> all-ones.
        n_low   = n_eff[WIDTH-1:0];
        half_lo = n_eff[WIDTH:1];
        half_hi = n_eff[WIDTH:1] + {{(WIDTH-1){1'b0}}, n_eff[0]};
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        out_nxt   = out;
        case (state)
            IDLE: begin
                if (bus.wr_en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (cen && gate) begin
                    count_nxt = mode_r ? half_hi : n_low;
                    out_nxt   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (gate_rise) begin
                    state_nxt = LOAD;
                end else if (cen && gate) begin
                    if (!mode_r) begin
                        if (count == TWO) begin
                            count_nxt = ONE;
                            out_nxt   = 1'b0;
                        end else if (count == ONE) begin
                            count_nxt = n_low;
                            out_nxt   = 1'b1;
                        end else begin
                            count_nxt = count - ONE;
                        end
                    end else begin
                        // The phase just finished picks the length of the next one.
                        if (count == ONE) begin
                            out_nxt   = ~out;
                            count_nxt = out ? half_lo : half_hi;
                        end else begin
                            count_nxt = count - ONE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!gate) begin
            out_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            out     <= 1'b1;
            running <= 1'b0;
            gate_d  <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            out     <= out_nxt;
            running <= (state_nxt == RUN);
            gate_d  <= gate;
        end
    end

    // A write landing on a reload edge is seen only from the following reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload <= '0;
            mode_r <= 1'b0;
        end else if (bus.wr_en) begin
            reload <= bus.wr_data;
            mode_r <= bus.wr_mode;
        end
    end

endmodule

// File: tb/tb_cen_timer.sv
// Directed bench for cen_timer: rate generator, square wave, gate, boundaries.
module tb_cen_timer;

    logic        clk;
    logic        reset_n;
    logic        cen;
    logic        gate;
    logic        out;
    logic [15:0] count;
    logic        running;
    logic [1:0]  fsm_state;

    int n_vec;
    int n_err;
    int hi_clks;

    cen_timer_if #(.WIDTH(16)) bus ();

    cen_timer #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cen       (cen),
        .gate      (gate),
        .bus       (bus),
        .out       (out),
        .count     (count),
        .running   (running),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n     = 1'b0;
        cen         = 1'b0;
        gate        = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.wr_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hi_clks = 0;
    endtask

    // drivers: each step ends 1 time unit after a rising edge
    task automatic step(input logic c);
        cen = c;
        @(posedge clk);
        #1;
        if (out === 1'b1) hi_clks++;
    endtask

    task automatic cen_pulse(input int k);
        for (int i = 1; i < k; i++) step(1'b0);
        step(1'b1);
    endtask

    task automatic write_reg(input logic [15:0] d, input logic m, input logic c);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        bus.wr_mode = m;
        cen         = c;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({out, count, running, fsm_state} !== {1'b1, 16'd0, 1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL reset_state: got out=%b count=%0d running=%b state=%0d, want 1/0/0/0",
                     out, count, running, fsm_state);
        end
        for (int i = 0; i < 6; i++) begin
            cen_pulse(2);
            n_vec++;
            if ({out, count, running} !== {1'b1, 16'd0, 1'b0}) begin
                n_err++;
                $display("FAIL idle_no_write[%0d]: got out=%b count=%0d running=%b, want 1/0/0",
                         i, out, count, running);
            end
        end
    endtask

    task automatic test_mode0_rate();
        int ec[8] = '{3, 2, 1, 4, 3, 2, 1, 4};
        bit eo[8] = '{1, 1, 0, 1, 1, 1, 0, 1};
        do_reset();
        write_reg(16'd4, 1'b0, 1'b0);
        n_vec++;
        if ({fsm_state, running} !== {2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL m0_after_write: got state=%0d running=%b, want 1/0", fsm_state, running);
        end
        cen_pulse(3);
        n_vec++;
        if ({out, count, running} !== {1'b1, 16'd4, 1'b1}) begin
            n_err++;
            $display("FAIL m0_load: got out=%b count=%0d running=%b, want 1/4/1", out, count, running);
        end
        hi_clks = 0;
        for (int i = 0; i < 8; i++) begin
            cen_pulse(3);
            n_vec++;
            if ({out, count} !== {eo[i], 16'(ec[i])}) begin
                n_err++;
                $display("FAIL m0_seq[%0d]: got out=%b count=%0d, want out=%b count=%0d",
                         i, out, count, eo[i], ec[i]);
            end
        end
        n_vec++;
        if (hi_clks !== 18) begin
            n_err++;
            $display("FAIL m0_high_clks: got %0d of 24, want 18", hi_clks);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_reg(16'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cen_pulse(2);
        n_vec++;
        if ({out, count} !== {1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL arst_pre: got out=%b count=%0d, want 0/1", out, count);
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({out, count, running, fsm_state} !== {1'b1, 16'd0, 1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL arst_async: got out=%b count=%0d running=%b state=%0d, want 1/0/0/0",
                     out, count, running, fsm_state);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cen_pulse(2);
            n_vec++;
            if ({out, count, running} !== {1'b1, 16'd0, 1'b0}) begin
                n_err++;
                $display("FAIL arst_after[%0d]: got out=%b count=%0d running=%b, want 1/0/0",
                         i, out, count, running);
            end
        end
    endtask

    task automatic test_mode1_square();
        int ec5[10] = '{2, 1, 2, 1, 3, 2, 1, 2, 1, 3};
        bit eo5[10] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 1};
        int ec4[8]  = '{1, 2, 1, 2, 1, 2, 1, 2};
        bit eo4[8]  = '{1, 0, 0, 1, 1, 0, 0, 1};
        do_reset();
        write_reg(16'd5, 1'b1, 1'b0);
        cen_pulse(3);
        n_vec++;
        if ({out, count, running} !== {1'b1, 16'd3, 1'b1}) begin
            n_err++;
            $display("FAIL m1n5_load: got out=%b count=%0d running=%b, want 1/3/1", out, count, running);
        end
        hi_clks = 0;
        for (int i = 0; i < 10; i++) begin
            cen_pulse(3);
            n_vec++;
            if ({out, count} !== {eo5[i], 16'(ec5[i])}) begin
                n_err++;
                $display("FAIL m1n5_seq[%0d]: got out=%b count=%0d, want out=%b count=%0d",
                         i, out, count, eo5[i], ec5[i]);
            end
        end
        n_vec++;
        if (hi_clks !== 18) begin
            n_err++;
            $display("FAIL m1n5_high_clks: got %0d of 30, want 18", hi_clks);
        end

        do_reset();
        write_reg(16'd4, 1'b1, 1'b0);
        cen_pulse(3);
        n_vec++;
        if ({out, count} !== {1'b1, 16'd2}) begin
            n_err++;
            $display("FAIL m1n4_load: got out=%b count=%0d, want 1/2", out, count);
        end
        hi_clks = 0;
        for (int i = 0; i < 8; i++) begin
            cen_pulse(3);
            n_vec++;
            if ({out, count} !== {eo4[i], 16'(ec4[i])}) begin
                n_err++;
                $display("FAIL m1n4_seq[%0d]: got out=%b count=%0d, want out=%b count=%0d",
                         i, out, count, eo4[i], ec4[i]);
            end
        end
        n_vec++;
        if (hi_clks !== 12) begin
            n_err++;
            $display("FAIL m1n4_high_clks: got %0d of 24, want 12", hi_clks);
        end
    endtask

    task automatic test_n1();
        int ec0[4] = '{2, 1, 2, 1};
        bit eo[4]  = '{1, 0, 1, 0};
        do_reset();
        write_reg(16'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cen_pulse(1);
            n_vec++;
            if ({out, count} !== {eo[i], 16'(ec0[i])}) begin
                n_err++;
                $display("FAIL n1_m0[%0d]: got out=%b count=%0d, want out=%b count=%0d",
                         i, out, count, eo[i], ec0[i]);
            end
        end
        do_reset();
        write_reg(16'd1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cen_pulse(1);
            n_vec++;
            if ({out, count} !== {eo[i], 16'd1}) begin
                n_err++;
                $display("FAIL n1_m1[%0d]: got out=%b count=%0d, want out=%b count=1",
                         i, out, count, eo[i]);
            end
        end
    endtask

    task automatic test_gate();
        do_reset();
        write_reg(16'd6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cen_pulse(1);
        n_vec++;
        if ({out, count} !== {1'b0, 16'd2}) begin
            n_err++;
            $display("FAIL gate_pre: got out=%b count=%0d, want 0/2", out, count);
        end
        gate = 1'b0;
        step(1'b0);
        n_vec++;
        if ({out, count, running} !== {1'b1, 16'd2, 1'b1}) begin
            n_err++;
            $display("FAIL gate_low: got out=%b count=%0d running=%b, want 1/2/1", out, count, running);
        end
        for (int i = 0; i < 3; i++) step(1'b1);
        n_vec++;
        if ({out, count} !== {1'b1, 16'd2}) begin
            n_err++;
            $display("FAIL gate_hold: got out=%b count=%0d, want 1/2", out, count);
        end
        gate = 1'b1;
        step(1'b0);
        n_vec++;
        if ({fsm_state, running, count} !== {2'd1, 1'b0, 16'd2}) begin
            n_err++;
            $display("FAIL gate_rise: got state=%0d running=%b count=%0d, want 1/0/2",
                     fsm_state, running, count);
        end
        step(1'b1);
        n_vec++;
        if ({out, count, running} !== {1'b1, 16'd3, 1'b1}) begin
            n_err++;
            $display("FAIL gate_retrig: got out=%b count=%0d running=%b, want 1/3/1", out, count, running);
        end
        step(1'b1);
        gate = 1'b0;
        step(1'b1);
        gate = 1'b1;
        step(1'b1);
        n_vec++;
        if ({fsm_state, count} !== {2'd1, 16'd2}) begin
            n_err++;
            $display("FAIL gate_rise_cen: got state=%0d count=%0d, want 1/2", fsm_state, count);
        end
        step(1'b1);
        n_vec++;
        if ({out, count, fsm_state} !== {1'b1, 16'd3, 2'd2}) begin
            n_err++;
            $display("FAIL gate_rise_cen_load: got out=%b count=%0d state=%0d, want 1/3/2",
                     out, count, fsm_state);
        end
    endtask

    task automatic test_write_running();
        do_reset();
        write_reg(16'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cen_pulse(1);
        n_vec++;
        if ({out, count} !== {1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL wr_pre: got out=%b count=%0d, want 0/1", out, count);
        end
        write_reg(16'd8, 1'b0, 1'b1);
        n_vec++;
        if ({out, count} !== {1'b1, 16'd4}) begin
            n_err++;
            $display("FAIL wr_old_reload: got out=%b count=%0d, want 1/4", out, count);
        end
        for (int i = 0; i < 3; i++) cen_pulse(1);
        cen_pulse(1);
        n_vec++;
        if ({out, count} !== {1'b1, 16'd8}) begin
            n_err++;
            $display("FAIL wr_new_reload: got out=%b count=%0d, want 1/8", out, count);
        end
        hi_clks = 0;
        for (int i = 0; i < 7; i++) cen_pulse(1);
        n_vec++;
        if ({out, count, hi_clks} !== {1'b0, 16'd1, 32'd6}) begin
            n_err++;
            $display("FAIL wr_spacing8: got out=%b count=%0d high=%0d, want 0/1/6", out, count, hi_clks);
        end
        cen_pulse(1);
        n_vec++;
        if ({out, count} !== {1'b1, 16'd8}) begin
            n_err++;
            $display("FAIL wr_second_reload: got out=%b count=%0d, want 1/8", out, count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_reg(16'd3, 1'b0, 1'b0);
        write_reg(16'd5, 1'b0, 1'b0);
        n_vec++;
        if (fsm_state !== 2'd1) begin
            n_err++;
            $display("FAIL b2b_state: got %0d, want 1", fsm_state);
        end
        cen_pulse(1);
        n_vec++;
        if ({out, count} !== {1'b1, 16'd5}) begin
            n_err++;
            $display("FAIL b2b_last_wins: got out=%b count=%0d, want 1/5", out, count);
        end
        cen_pulse(1);
        n_vec++;
        if (count !== 16'd4) begin
            n_err++;
            $display("FAIL b2b_dec: got count=%0d, want 4", count);
        end
    endtask

    task automatic test_n0();
        do_reset();
        write_reg(16'd0, 1'b0, 1'b0);
        cen_pulse(1);
        n_vec++;
        if ({out, count, running} !== {1'b1, 16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL n0_m0_load: got out=%b count=%h running=%b, want 1/0000/1", out, count, running);
        end
        cen_pulse(1);
        n_vec++;
        if ({out, count} !== {1'b1, 16'hFFFF}) begin
            n_err++;
            $display("FAIL n0_m0_wrap: got out=%b count=%h, want 1/ffff", out, count);
        end
        cen_pulse(1);
        n_vec++;
        if (count !== 16'hFFFE) begin
            n_err++;
            $display("FAIL n0_m0_dec: got count=%h, want fffe", count);
        end

        do_reset();
        write_reg(16'd0, 1'b1, 1'b0);
        cen_pulse(1);
        n_vec++;
        if ({out, count} !== {1'b1, 16'h8000}) begin
            n_err++;
            $display("FAIL n0_m1_load: got out=%b count=%h, want 1/8000", out, count);
        end
        hi_clks = 0;
        for (int i = 0; i < 32767; i++) cen_pulse(1);
        n_vec++;
        if ({out, count, hi_clks} !== {1'b1, 16'd1, 32'd32767}) begin
            n_err++;
            $display("FAIL n0_m1_high_half: got out=%b count=%0d high=%0d, want 1/1/32767",
                     out, count, hi_clks);
        end
        cen_pulse(1);
        n_vec++;
        if ({out, count} !== {1'b0, 16'h8000}) begin
            n_err++;
            $display("FAIL n0_m1_low_half: got out=%b count=%h, want 0/8000", out, count);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        hi_clks = 0;
        test_reset();
        test_mode0_rate();
        test_async_reset();
        test_mode1_square();
        test_n1();
        test_gate();
        test_write_running();
        test_back_to_back();
        test_n0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cen_timer.md
# cen_timer

Programmable 16-bit timer channel clocked from a single system clock and advanced only by a one-cycle clock-enable strobe (`cen`). It consumes the 1-in-N enable pulse produced by the clock-divider stage. It generates either a rate-generator pulse train or a square wave on `out`, in the manner of an 8253 channel. The reload value is written by the bus side; `gate` freezes or retriggers counting.

## Interface
- WIDTH, 16, counter and reload width; a written value of 0 means 2^WIDTH.
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cen  in  1  count enable: one-`clk` strobe from the divider; counting advances only on `clk` edges where `cen`=1.
- gate  in  1  count gate; 0 freezes counting and forces `out` high.
- wr_en  in  1  one-`clk` write strobe for reload value and mode.
- wr_data  in  WIDTH  reload value N.
- wr_mode  in  1  0 = rate generator, 1 = square wave; latched on `wr_en`.
- out  out  1  timer output.
- count  out  WIDTH  current counter value.
- running  out  1  high while in state RUN.

## Operation
- Registers: `reload` (WIDTH), `mode_r`, `count` (WIDTH), `out`, `gate_d` (previous `gate`), `state` ∈ {IDLE, LOAD, RUN}.
- Reset (async): state IDLE, `count`=0, `reload`=0, `mode_r`=0, `out`=1, `running`=0.
- Write: on `wr_en`, `reload`←`wr_data` and `mode_r`←`wr_mode`.
  - If IDLE, the next state is LOAD.
  - If LOAD or RUN, state is unchanged; the new value applies at the next reload event.
- Effective N: `wr_data`=1 is treated as 2. A value of 0 is 2^WIDTH; arithmetic uses WIDTH+1 bits.
- Phase lengths for the square wave: H = ceil(N/2), L = floor(N/2).
- LOAD, on `cen` & `gate`:
  - `count` ← N in mode 0, or ← H in mode 1.
  - `out` ← 1; state ← RUN.
- RUN, mode 0 (rate generator), on `cen` & `gate`:
  - `count`=2 → `count`←1, `out`←0.
  - `count`=1 → `count`←N, `out`←1.
  - Otherwise → `count`←`count`−1, with modular wrap (0 → all-ones).
  - Result: `out` is low for exactly one `cen` period per N `cen` periods.
- RUN, mode 1 (square wave), on `cen` & `gate`:
  - `count`=1 → `out`←~`out`, and `count`←L if `out` was 1, else H.
  - Otherwise → `count`←`count`−1.
  - Result: `out` is high for H and low for L `cen` periods.
- Gate:
  - While `gate`=0: `count` is held and `out`=1, forced on the next `clk` edge.
  - Rising edge of `gate` (`gate`=1, `gate_d`=0) while in RUN: state ← LOAD, i.e. retrigger.
- Simultaneous events:
  - `wr_en` coinciding with a reload or LOAD uses the old `reload`/`mode_r`; the new value is used from the following reload.
  - A `gate` rising edge coinciding with `cen` goes to LOAD; no count occurs that cycle.
- `reset_n` asserted mid-count returns all outputs to their reset values immediately, without waiting for `clk`.

## Timing
- All outputs are registered. `out`, `count` and `running` change on the `clk` edge that samples `cen`=1, or on the edge after a `gate` fall for the forced-high `out`.
- Write latency:
  - A write at edge t moves IDLE→LOAD at t.
  - The first `cen` sampled at edge ≥ t+1 loads the counter and raises `running`.
- With `cen` every K clocks, the output period is N·K clocks.
- No handshake on `wr_en`; back-to-back writes are legal and the last one wins.

## Test plan
- Reset: assert `reset_n`=0 asynchronously mid-run → `out`=1, `count`=0, `running`=0 without a `clk` edge. After release with no write, `out` stays 1 indefinitely.
- Mode 0, N=4, `cen` every 3 clk, `gate`=1 → `out` low for 3 clk and high for 9 clk, repeating; `count` sequence 4,3,2,1,4.
- Mode 1, N=5, `cen` every 3 clk → `out` high for 9 clk (H=3) and low for 6 clk (L=2); period 15 clk. With N=4 → 6/6 clk.
- Boundaries:
  - N=0, mode 1 → half-periods of 32768 `cen` each.
  - N=1 → behaves as N=2.
  - Mode 0, N=0 → `count` wraps 0→0xFFFF and `out` pulses once per 65536 `cen`.
- Gate: mode 1, N=6. Drop `gate` at `count`=2 in the low phase → `out` forced 1 next edge and `count` held at 2. Raise `gate` → at the next `cen`, `count`=3 and `out`=1.
- Write while running: mode 0, N=4, then write N=8 with `cen` and `count`=1 in the same cycle → that reload uses 4. The following reload uses 8, and the pulse spacing becomes 8 `cen`.
